// File: rtl/sync_pol_pkg.sv
// Shared defaults and helpers for the multi-channel sync polarity normaliser.
// Used by sync_pol_chan and sync_pol_norm.
package sync_pol_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int CONFIRM_DEF = 2;
  localparam int CONF_W_DEF  = $clog2(CONFIRM_DEF + 1);

  function automatic int conf_width(input int confirm);
    return $clog2(confirm + 1);
  endfunction

  // Counters up to 31 bits wide stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] top;
    top = (32'd1 << width) - 32'd1;
    return (val >= top) ? top : val + 32'd1;
  endfunction

endpackage

// File: rtl/sync_pol_chan.sv
// One sync channel: synchroniser, phase counter, polarity hysteresis and loss detection.
// Defining SYNC_POL_MEAS_EN adds active-width and period measurement.
module sync_pol_chan
  import sync_pol_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int CONFIRM = CONFIRM_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync_in,
  output logic             sync_out,
  output logic             pol,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] meas_active,
  output logic [CNT_W:0]   meas_total,
  output logic             meas_valid
);

  localparam int                CONF_W    = conf_width(CONFIRM);
  localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CONF_W-1:0] CONFIRM_V = CONF_W'(CONFIRM);

  logic              s1, s2, s3;
  logic              rise, fall, edge_det, decide, cand;
  logic [CNT_W-1:0]  cnt, cnt_n, len_hi, len_hi_n, len_lo, len_lo_n;
  logic [CONF_W-1:0] conf, conf_n, conf_inc;
  logic              seen_rise, seen_rise_n, seen_fall, seen_fall_n;
  logic              pol_n, lost_n;

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign edge_det = rise | fall;
  assign conf_inc = conf + CONF_W'(1);

  // An edge always beats a coincident timeout; lengths are captured before the decision.
  always_comb begin
    cnt_n       = CNT_W'(sat_inc(32'(cnt), CNT_W));
    len_hi_n    = len_hi;
    len_lo_n    = len_lo;
    seen_rise_n = seen_rise;
    seen_fall_n = seen_fall;
    conf_n      = conf;
    pol_n       = pol;
    lost_n      = lost;
    decide      = 1'b0;
    cand        = pol;
    if (edge_det) begin
      cnt_n  = '0;
      lost_n = 1'b0;
      if (rise) begin
        len_lo_n    = cnt;
        seen_rise_n = 1'b1;
      end else begin
        len_hi_n    = cnt;
        seen_fall_n = 1'b1;
      end
      decide = seen_rise_n & seen_fall_n;
      if (len_hi_n > len_lo_n) begin
        cand = 1'b1;
      end else if (len_hi_n < len_lo_n) begin
        cand = 1'b0;
      end
      if (decide) begin
        if (cand == pol) begin
          conf_n = '0;
        end else if (conf_inc == CONFIRM_V) begin
          pol_n  = cand;
          conf_n = '0;
        end else begin
          conf_n = conf_inc;
        end
      end
    end else if (cnt == TIMEOUT_V) begin
      lost_n      = 1'b1;
      seen_rise_n = 1'b0;
      seen_fall_n = 1'b0;
      conf_n      = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      len_hi    <= '0;
      len_lo    <= '0;
      seen_rise <= 1'b0;
      seen_fall <= 1'b0;
      conf      <= '0;
      pol       <= 1'b0;
      lost      <= 1'b0;
      locked    <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      s1        <= sync_in;
      s2        <= s1;
      s3        <= s2;
      cnt       <= cnt_n;
      len_hi    <= len_hi_n;
      len_lo    <= len_lo_n;
      seen_rise <= seen_rise_n;
      seen_fall <= seen_fall_n;
      conf      <= conf_n;
      pol       <= pol_n;
      lost      <= lost_n;
      locked    <= seen_rise_n & seen_fall_n & ~lost_n;
      sync_out  <= ~lost & (s2 ^ pol);
    end
  end

`ifdef SYNC_POL_MEAS_EN
  logic [CNT_W:0] len_sum;

  assign len_sum = {1'b0, len_hi_n} + {1'b0, len_lo_n};

  // Active width follows the polarity as updated by this same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meas_active <= '0;
      meas_total  <= '0;
      meas_valid  <= 1'b0;
    end else begin
      meas_valid <= decide;
      if (decide) begin
        meas_active <= pol_n ? len_lo_n : len_hi_n;
        meas_total  <= len_sum;
      end
    end
  end
`else
  assign meas_active = '0;
  assign meas_total  = '0;
  assign meas_valid  = 1'b0;
`endif

endmodule

// File: rtl/sync_pol_norm.sv
// NCH independent sync polarity normalisers with flattened per-channel ports.
// Measurement outputs are live only when SYNC_POL_MEAS_EN is defined.
module sync_pol_norm
  import sync_pol_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int CONFIRM = CONFIRM_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH-1:0]           sync_in,
  output logic [NCH-1:0]           sync_out,
  output logic [NCH-1:0]           pol,
  output logic [NCH-1:0]           locked,
  output logic [NCH-1:0]           lost,
  output logic [NCH*CNT_W-1:0]     meas_active,
  output logic [NCH*(CNT_W+1)-1:0] meas_total,
  output logic [NCH-1:0]           meas_valid
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    sync_pol_chan #(
      .CNT_W  (CNT_W),
      .CONFIRM(CONFIRM),
      .TIMEOUT(TIMEOUT)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .sync_in    (sync_in[i]),
      .sync_out   (sync_out[i]),
      .pol        (pol[i]),
      .locked     (locked[i]),
      .lost       (lost[i]),
      .meas_active(meas_active[i*CNT_W +: CNT_W]),
      .meas_total (meas_total[i*(CNT_W+1) +: CNT_W+1]),
      .meas_valid (meas_valid[i])
    );
  end

endmodule

// File: tb/tb_sync_pol_norm.sv
// Randomised bench for sync_pol_norm against a timestamp-based phase model.
// Measurement expectations follow SYNC_POL_MEAS_EN.
module tb_sync_pol_norm;

  localparam int NCH     = 2;
  localparam int CNT_W   = 16;
  localparam int CONFIRM = 2;
  localparam int TIMEOUT = 300;
  localparam int SAT     = (1 << CNT_W) - 1;
`ifdef SYNC_POL_MEAS_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NCH-1:0]           sync_in = '0;
  logic [NCH-1:0]           sync_out, pol, locked, lost, meas_valid;
  logic [NCH*CNT_W-1:0]     meas_active;
  logic [NCH*(CNT_W+1)-1:0] meas_total;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_pol_norm #(
    .NCH(NCH), .CNT_W(CNT_W), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .sync_in(sync_in), .sync_out(sync_out),
    .pol(pol), .locked(locked), .lost(lost), .meas_active(meas_active),
    .meas_total(meas_total), .meas_valid(meas_valid)
  );

  // Model: input history plus the clock index of each channel's last edge.
  logic [NCH-1:0] hist[$];
  int cyc;
  int last_edge[NCH], len_hi[NCH], len_lo[NCH], conf[NCH];
  bit seen_r[NCH], seen_f[NCH], m_pol[NCH], m_lost[NCH];
  logic [NCH-1:0] e_sync, e_pol, e_locked, e_lost, e_valid;
  logic [NCH*CNT_W-1:0] e_active;
  logic [NCH*(CNT_W+1)-1:0] e_total;

  int level[NCH], remain[NCH], hi_len[NCH], lo_len[NCH];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit sampleAt(input int k, input int c);
    if (k < 0) return 1'b0;
    return hist[k][c];
  endfunction

  task automatic modelReset();
    cyc = 0;
    for (int c = 0; c < NCH; c++) begin
      last_edge[c] = 0; len_hi[c] = 0; len_lo[c] = 0; conf[c] = 0;
      seen_r[c] = 0; seen_f[c] = 0; m_pol[c] = 0; m_lost[c] = 0;
    end
    e_sync = '0; e_pol = '0; e_locked = '0; e_lost = '0; e_valid = '0;
    e_active = '0; e_total = '0;
    hist.delete();
    hist.push_back(sync_in);
  endtask

  // Clock k sees the input driven k-3 cycles earlier; a phase spans edge to edge.
  task automatic modelStep();
    for (int c = 0; c < NCH; c++) begin
      bit a, b, want;
      int elapsed, cap;
      a = sampleAt(cyc - 3, c);
      b = sampleAt(cyc - 4, c);
      e_sync[c] = m_lost[c] ? 1'b0 : (a ^ m_pol[c]);
      elapsed = cyc - 1 - last_edge[c];
      cap = (elapsed > SAT) ? SAT : elapsed;
      e_valid[c] = 1'b0;
      if (a != b) begin
        last_edge[c] = cyc;
        m_lost[c] = 0;
        if (a) begin len_lo[c] = cap; seen_r[c] = 1; end
        else begin len_hi[c] = cap; seen_f[c] = 1; end
        if (seen_r[c] && seen_f[c]) begin
          want = (len_hi[c] > len_lo[c]) ? 1'b1 : (len_hi[c] < len_lo[c]) ? 1'b0 : m_pol[c];
          if (want == m_pol[c]) conf[c] = 0;
          else begin
            conf[c]++;
            if (conf[c] == CONFIRM) begin m_pol[c] = want; conf[c] = 0; end
          end
          e_valid[c] = MEAS;
          e_active[c*CNT_W +: CNT_W] = MEAS ? CNT_W'(m_pol[c] ? len_lo[c] : len_hi[c]) : '0;
          e_total[c*(CNT_W+1) +: CNT_W+1] = MEAS ? (CNT_W+1)'(len_hi[c] + len_lo[c]) : '0;
        end
      end else if (elapsed == TIMEOUT) begin
        m_lost[c] = 1; seen_r[c] = 0; seen_f[c] = 0; conf[c] = 0;
      end
      e_pol[c] = m_pol[c];
      e_lost[c] = m_lost[c];
      e_locked[c] = seen_r[c] && seen_f[c] && !m_lost[c];
    end
  endtask

  task automatic setPattern(input int c, input int hi, input int lo);
    hi_len[c] = hi;
    lo_len[c] = lo;
  endtask

  // A channel with hi_len == 0 is held idle low.
  task automatic applyStimulus(input int ncycles);
    for (int n = 0; n < ncycles; n++) begin
      logic [NCH-1:0] nxt;
      for (int c = 0; c < NCH; c++) begin
        if (hi_len[c] == 0) nxt[c] = 1'b0;
        else begin
          if (remain[c] <= 0) begin
            level[c] = (level[c] == 0) ? 1 : 0;
            remain[c] = (level[c] != 0) ? hi_len[c] : lo_len[c];
          end
          remain[c]--;
          nxt[c] = (level[c] != 0);
        end
      end
      @(posedge clk);
      cyc++;
      modelStep();
      #1 sync_in = nxt;
      hist.push_back(nxt);
      @(negedge clk);
      checkOutput("sync_out", 64'(sync_out), 64'(e_sync));
      checkOutput("pol", 64'(pol), 64'(e_pol));
      checkOutput("locked", 64'(locked), 64'(e_locked));
      checkOutput("lost", 64'(lost), 64'(e_lost));
      checkOutput("meas_valid", 64'(meas_valid), 64'(e_valid));
      checkOutput("meas_active", 64'(meas_active), 64'(e_active));
      checkOutput("meas_total", 64'(meas_total), 64'(e_total));
    end
  endtask

  task automatic waitPhase(input int c, input int lvl);
    int n = 0;
    while (level[c] != lvl && n < 1000) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("phase_wait", 64'(level[c]), 64'(lvl));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_sync_out"}, 64'(sync_out), 64'd0);
    checkOutput({tag, "_pol"}, 64'(pol), 64'd0);
    checkOutput({tag, "_locked"}, 64'(locked), 64'd0);
    checkOutput({tag, "_lost"}, 64'(lost), 64'd0);
    checkOutput({tag, "_valid"}, 64'(meas_valid), 64'd0);
    checkOutput({tag, "_active"}, 64'(meas_active), 64'd0);
    checkOutput({tag, "_total"}, 64'(meas_total), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NCH*CNT_W-1:0] exp_act;
    logic [NCH*(CNT_W+1)-1:0] exp_tot;
    exp_act = MEAS ? {16'd9, 16'd9} : '0;
    exp_tot = MEAS ? {17'd98, 17'd98} : '0;
    for (int c = 0; c < NCH; c++) begin
      level[c] = 0; remain[c] = 0; hi_len[c] = 0; lo_len[c] = 0;
    end
    cyc = 0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    modelReset();

    $display("[TB] idle low until timeout");
    applyStimulus(TIMEOUT + 5);
    checkOutput("idle_lost", 64'(lost), 64'd3);

    $display("[TB] ch0 active-low 90/10, ch1 active-high 10/90");
    setPattern(0, 90, 10);
    setPattern(1, 10, 90);
    applyStimulus(600);
    checkOutput("settle_pol", 64'(pol), 64'd1);
    checkOutput("settle_locked", 64'(locked), 64'd3);
    checkOutput("settle_active", 64'(meas_active), 64'(exp_act));
    checkOutput("settle_total", 64'(meas_total), 64'(exp_tot));

    $display("[TB] single inverted period on ch1");
    waitPhase(1, 0);
    setPattern(1, 90, 10);
    waitPhase(1, 1);
    waitPhase(1, 0);
    setPattern(1, 10, 90);
    applyStimulus(300);
    checkOutput("glitch_pol", 64'(pol), 64'd1);

    $display("[TB] 50/50 square wave");
    setPattern(0, 50, 50);
    setPattern(1, 50, 50);
    applyStimulus(500);
    checkOutput("square_pol", 64'(pol), 64'd1);
    checkOutput("square_total", 64'(meas_total), 64'(exp_tot));

    $display("[TB] random periods with idle gaps");
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < NCH; c++)
        setPattern(c, int'($urandom_range(3, 60)), int'($urandom_range(3, 60)));
      applyStimulus(int'($urandom_range(300, 600)));
      if (r == 2) begin
        setPattern(0, 0, 0);
        setPattern(1, 0, 0);
        applyStimulus(TIMEOUT + 20);
      end
    end

    $display("[TB] reset mid-line then relock");
    setPattern(0, 90, 10);
    setPattern(1, 10, 90);
    applyStimulus(250);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkAllZero("midrst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    applyStimulus(600);
    checkOutput("relock_pol", 64'(pol), 64'd1);
    checkOutput("relock_locked", 64'(locked), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
